// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter. It puts requester 0 and requester 1 onto one
// single-port memory, one transaction at a time. Each transaction is one IDLE
// cycle in which it is accepted, followed by one ACCESS cycle.
// Arbitration is round-robin by default.
// Define DM_ARB_FIXED_PRIO_EN to make port 0 always win contention.
module dm_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [11:0] addr0,
  input  logic [11:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        port_q, port_d;      // ID of the requester owning ACCESS
  logic        last_q, last_d;      // port granted most recently
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        rvalid0_q, rvalid0_d;
  logic        rvalid1_q, rvalid1_d;
  logic [31:0] rdata_q, rdata_d;
  logic        win;                 // 0 = port 0 wins, 1 = port 1 wins

  // Pick the winning port from the current requests.
  always_comb begin
    win = 1'b0;
`ifdef DM_ARB_FIXED_PRIO_EN
    win = ~req0;
`else
    if (req0 && req1) begin
      win = ~last_q;
    end else begin
      win = ~req0;
    end
`endif
  end

  // Next-state: accept a request in IDLE, retire it at the end of ACCESS.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    port_d    = port_q;
    last_d    = last_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d = StAccess;
          port_d  = win;
          last_d  = win;
          we_d    = win ? we1 : we0;
          addr_d  = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          gnt0_d  = ~win;
          gnt1_d  = win;
        end
      end
      StAccess: begin
        // Requests seen here are ignored; the requester must still be asking in IDLE.
        state_d = StIdle;
        if (!we_q) begin
          rdata_d   = mem_rdata;
          rvalid0_d = ~port_q;
          rvalid1_d = port_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; synchronous reset discards any open transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      port_q    <= 1'b0;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      port_q    <= port_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata_q   <= rdata_d;
    end
  end

  // Memory port is quiet outside ACCESS; reset also blocks a write in flight.
  always_comb begin
    mem_we    = (state_q == StAccess) && we_q && !reset;
    mem_addr  = (state_q == StAccess) ? addr_q : 12'h000;
    mem_wdata = (state_q == StAccess) ? wdata_q : 32'h0000_0000;
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter. It has a behavioural memory and a
// transaction-level reference model, and uses directed scenarios followed by
// random traffic.
module tb_dm_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [11:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  dm_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .we0       (we0),
    .we1       (we1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata     (rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: combinational read, write on rising edge.
  logic [31:0] tb_mem [4096];
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr] = mem_wdata;

  // Mutual exclusion of the grant and valid pulses.
  always @(negedge clk) begin
    assert (!(gnt0 && gnt1)) else $error("FAIL excl_gnt got both grants");
    assert (!(rvalid0 && rvalid1)) else $error("FAIL excl_rvalid got both rvalids");
  end

  // ---------------- reference model ----------------
  // A transaction accepted at edge n holds the memory until edge n+1.
  // Its grant is visible between n and n+1. A read is delivered between
  // n+1 and n+2.
  logic [31:0] model_mem [4096];
  int          cyc = 0;
  int          acc_cyc = 0;
  bit          pend = 0;
  bit          last = 1;
  bit          t_port, t_we;
  logic [11:0] t_addr;
  logic [31:0] t_wdata;
  logic [1:0]  e_gnt, e_rv;
  logic        e_mem_we;
  logic [11:0] e_mem_addr;
  logic [31:0] e_mem_wdata, e_rdata;

  task automatic model_edge();
    bit w;
    e_gnt = '0; e_rv = '0; e_mem_we = 0; e_mem_addr = '0; e_mem_wdata = '0;
    if (reset) begin
      pend = 0; last = 1; e_rdata = '0;
    end else if (pend && cyc == acc_cyc + 1) begin
      pend = 0;
      if (t_we) model_mem[t_addr] = t_wdata;
      else begin
        e_rdata = model_mem[t_addr];
        e_rv[t_port] = 1'b1;
      end
    end else if (req0 || req1) begin
      if (req0 && req1) begin
`ifdef DM_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = ~last;
`endif
      end else w = req1;
      pend = 1; acc_cyc = cyc; last = w; t_port = w;
      t_we    = w ? we1 : we0;
      t_addr  = w ? addr1 : addr0;
      t_wdata = w ? wdata1 : wdata0;
      e_gnt[w] = 1'b1;
      e_mem_we = t_we; e_mem_addr = t_addr; e_mem_wdata = t_wdata;
    end
    cyc++;
  endtask

  function automatic logic [80:0] obs();
    return {gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_addr, mem_wdata, rdata};
  endfunction

  function automatic logic [80:0] exp_vec();
    return {e_gnt[0], e_gnt[1], e_rv[0], e_rv[1], e_mem_we, e_mem_addr, e_mem_wdata, e_rdata};
  endfunction

  // Advance one clock; the model sees the same inputs the DUT sampled.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [11:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [11:0] a1, input logic [31:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(1, 0, 12'h001, 0, 1, 0, 12'h002, 0);
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL reset step%0d got %h exp %h", i, obs(), exp_vec());
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    int we_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       drive(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 0, 0);
        2:       drive(1, 0, 12'h010, 32'h0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      cycle();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL write_read step%0d got %h exp %h", i, obs(), exp_vec());
      end
      if (mem_we) we_pulses++;
      if (i == 1) begin
        checks++;
        if (tb_mem[12'h010] !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL write_read_mem got %h exp deadbeef", tb_mem[12'h010]);
        end
      end
      if (i == 3) begin
        checks++;
        if (rvalid0 !== 1'b1 || rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL write_read_rvalid got rvalid0=%b rdata=%h exp 1 deadbeef",
                   rvalid0, rdata);
        end
      end
    end
    checks++;
    if (we_pulses != 1) begin
      errors++;
      $display("FAIL write_read_we_pulses got %0d exp 1", we_pulses);
    end
  endtask

  task automatic test_contention();
    logic [3:0] order = '0;
    logic [3:0] want;
    int         n = 0;
`ifdef DM_ARB_FIXED_PRIO_EN
    want = 4'b0000;
`else
    want = 4'b1010;  // bit i = port granted in transaction i: 0,1,0,1
`endif
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drive(1, 0, 12'h010, 0, 1, 0, 12'h020, 0);
    for (int i = 0; i < 9; i++) begin
      if (i == 8) drive(0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL contention step%0d got %h exp %h", i, obs(), exp_vec());
      end
      if ((gnt0 || gnt1) && n < 4) begin
        order[n] = gnt1;
        n++;
      end
    end
    checks++;
    if (n != 4 || order !== want) begin
      errors++;
      $display("FAIL contention_order got n=%0d order=%b exp n=4 order=%b", n, order, want);
    end
  endtask

  task automatic test_single_req1();
    tb_mem[12'hFFF] = 32'h12345678;
    model_mem[12'hFFF] = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(0, 0, 0, 0, 1, 0, 12'hFFF, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0, 0);
      cycle();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL single_req1 step%0d got %h exp %h", i, obs(), exp_vec());
      end
      checks++;
      if (gnt0 !== 1'b0 || rvalid0 !== 1'b0
          || gnt1 !== (i == 0) || rvalid1 !== (i == 1)) begin
        errors++;
        $display("FAIL single_req1_pulses step%0d got g0=%b g1=%b v0=%b v1=%b", i,
                 gnt0, gnt1, rvalid0, rvalid1);
      end
    end
    checks++;
    if (rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL single_req1_rdata got %h exp 12345678", rdata);
    end
  endtask

  task automatic test_reset_during_access();
    int rv_seen = 0;
    tb_mem[12'h004] = 32'hA5A5A5A5;
    model_mem[12'h004] = 32'hA5A5A5A5;
    drive(0, 0, 0, 0, 1, 1, 12'h004, 32'h5);
    cycle();
    checks++;
    if (obs() !== exp_vec()) begin
      errors++;
      $display("FAIL rst_access accept got %h exp %h", obs(), exp_vec());
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_access_we got %b exp 0", mem_we);
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      reset = 1'b0;
      checks++;
      if (obs() !== exp_vec() || obs() !== '0) begin
        errors++;
        $display("FAIL rst_access step%0d got %h exp 0", i, obs());
      end
      if (rvalid0 || rvalid1) rv_seen++;
    end
    checks++;
    if (tb_mem[12'h004] !== 32'hA5A5A5A5 || rv_seen != 0) begin
      errors++;
      $display("FAIL rst_access_mem got %h rv=%0d exp a5a5a5a5 rv=0", tb_mem[12'h004], rv_seen);
    end
  endtask

  task automatic test_ignore_in_access();
    int g0_seen = 0;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(0, 0, 0, 0, 1, 0, 12'h020, 0);
        1:       drive(1, 0, 12'h030, 0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      cycle();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL ignore step%0d got %h exp %h", i, obs(), exp_vec());
      end
      if (gnt0) g0_seen++;
    end
    checks++;
    if (g0_seen != 0) begin
      errors++;
      $display("FAIL ignore_gnt0 got %0d grants exp 0", g0_seen);
    end
  endtask

  task automatic test_random();
    int grants = 0;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      req0 = $urandom_range(0, 1) != 0;
      req1 = $urandom_range(0, 1) != 0;
      we0  = $urandom_range(0, 1) != 0;
      we1  = $urandom_range(0, 1) != 0;
      addr0 = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      addr1 = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      wdata0 = $urandom;
      wdata1 = $urandom;
      cycle();
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc%0d got %h exp %h", i, obs(), exp_vec());
      end
      if (gnt0 || gnt1) grants++;
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (tb_mem[a] !== model_mem[a]) begin
        errors++;
        $display("FAIL random_mem addr%0d got %h exp %h", a, tb_mem[a], model_mem[a]);
      end
    end
    checks++;
    if (grants < 50) begin
      errors++;
      $display("FAIL random_activity got %0d grants exp at least 50", grants);
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      tb_mem[a] = 32'hC0DE0000 + 32'(a);
      model_mem[a] = 32'hC0DE0000 + 32'(a);
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_write_read();
    test_contention();
    test_single_req1();
    test_reset_during_access();
    test_ignore_in_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
